// File: rtl/simd_operand_streamer.sv
// Burst source for the SIMD top level: a host-loaded operand-pair buffer streamed out
// one pair per clock. A start is accepted only in IDLE, and the buffer is frozen while a burst runs.
`timescale 1ns/1ps
module simd_operand_streamer #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data_a,
  input  logic [DATA_W-1:0] wr_data_b,
  input  logic              start,
  input  logic [2:0]        start_instruction,
  input  logic [5:0]        start_size,
  output logic              busy,
  output logic              done,
  output logic              valid_data,
  output logic              valid_instruction,
  output logic [2:0]        instruction,
  output logic [5:0]        data_size,
  output logic [DATA_W-1:0] mc_data_in_opa,
  output logic [DATA_W-1:0] mc_data_in_opb
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STREAM, S_FIN} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_ptr;
  logic [5:0]          r_beat;
  logic [2:0]          r_instr;
  logic [5:0]          r_size;
  logic [2*DATA_W-1:0] r_mem [DEPTH];
  logic [2*DATA_W-1:0] r_pair_p1;
  logic                w_wr_ok;
  logic                w_last;
  logic                w_load;
  logic                w_vld_p1;

  assign w_wr_ok  = (r_state == S_IDLE) || (r_state == S_FIN);
  assign w_last   = (r_beat == (r_size - 6'd1));
  assign w_load   = (r_state == S_FETCH) || ((r_state == S_STREAM) && !w_last);
  assign w_vld_p1 = (r_state == S_STREAM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = (start_size != 6'd0) ? S_FETCH : S_FIN;
      S_FETCH:  w_next = S_STREAM;
      S_STREAM: if (w_last) w_next = S_FIN;
      S_FIN:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Control: pointer, beat counter and the latched command
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr   <= '0;
      r_beat  <= '0;
      r_instr <= '0;
      r_size  <= '0;
    end else begin
      if ((r_state == S_IDLE) && start) begin
        r_instr <= start_instruction;
        r_size  <= start_size;
        r_ptr   <= '0;
        r_beat  <= '0;
      end else if (r_state == S_FETCH) begin
        r_ptr  <= r_ptr + ADDR_W'(1);
        r_beat <= '0;
      end else if ((r_state == S_STREAM) && !w_last) begin
        r_ptr  <= r_ptr + ADDR_W'(1);
        r_beat <= r_beat + 6'd1;
      end
    end
  end

  // Buffer is not reset; contents survive a reset
  always_ff @(posedge clk) begin
    if (wr_en && w_wr_ok) r_mem[wr_addr] <= {wr_data_a, wr_data_b};
  end

  // Stage p1: beat register, zeroed at the output whenever no beat is valid
  always_ff @(posedge clk) begin
    if (w_load) r_pair_p1 <= r_mem[r_ptr];
  end

  assign busy              = (r_state == S_FETCH) || (r_state == S_STREAM);
  assign done              = (r_state == S_FIN);
  assign valid_data        = w_vld_p1;
  assign valid_instruction = w_vld_p1;
  assign instruction       = r_instr;
  assign data_size         = r_size;
  assign mc_data_in_opa    = w_vld_p1 ? r_pair_p1[2*DATA_W-1:DATA_W] : '0;
  assign mc_data_in_opb    = w_vld_p1 ? r_pair_p1[DATA_W-1:0]        : '0;

endmodule

// File: tb/tb_simd_operand_streamer.sv
// Scoreboard bench for simd_operand_streamer: directed bursts push expected beats,
// a negedge monitor pops and compares every beat and every done pulse.
`timescale 1ns/1ps
module tb_simd_operand_streamer;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [63:0] wr_data_a;
  logic [63:0] wr_data_b;
  logic        start;
  logic [2:0]  start_instruction;
  logic [5:0]  start_size;
  logic        busy;
  logic        done;
  logic        valid_data;
  logic        valid_instruction;
  logic [2:0]  instruction;
  logic [5:0]  data_size;
  logic [63:0] mc_data_in_opa;
  logic [63:0] mc_data_in_opb;

  simd_operand_streamer #(.DEPTH(64), .ADDR_W(6), .DATA_W(64)) u_dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data_a(wr_data_a), .wr_data_b(wr_data_b), .start(start),
    .start_instruction(start_instruction), .start_size(start_size),
    .busy(busy), .done(done), .valid_data(valid_data),
    .valid_instruction(valid_instruction), .instruction(instruction),
    .data_size(data_size), .mc_data_in_opa(mc_data_in_opa),
    .mc_data_in_opb(mc_data_in_opb)
  );

  always #5 clk = ~clk;

  int           tests = 0;
  int           fails = 0;
  logic [127:0] shadow [64];
  logic [127:0] exp_q [$];
  int           exp_done = 0;
  logic [2:0]   exp_ins = '0;
  logic [5:0]   exp_sz = '0;
  logic [127:0] mon_e;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (valid_data) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_beat: got opa=%0h opb=%0h with no beat expected at %0t",
                   mc_data_in_opa, mc_data_in_opb, $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat_opa", {64'd0, mc_data_in_opa}, {64'd0, mon_e[127:64]});
          chk("beat_opb", {64'd0, mc_data_in_opb}, {64'd0, mon_e[63:0]});
          chk("beat_vi", {127'd0, valid_instruction}, 128'd1);
          chk("beat_instr", {125'd0, instruction}, {125'd0, exp_ins});
          chk("beat_size", {122'd0, data_size}, {122'd0, exp_sz});
        end
      end else begin
        chk("idle_opab_zero", {mc_data_in_opa, mc_data_in_opb}, 128'd0);
        chk("idle_vi_zero", {127'd0, valid_instruction}, 128'd0);
      end
      if (done) begin
        tests++;
        if (exp_done == 0) begin
          fails++;
          $display("FAIL unexpected_done: got done=1 expected 0 at %0t", $time);
        end else begin
          exp_done--;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wr(input int a, input logic [63:0] da, input logic [63:0] db);
    wr_en = 1'b1; wr_addr = 6'(a); wr_data_a = da; wr_data_b = db;
    cyc();
    wr_en = 1'b0;
    shadow[a] = {da, db};
  endtask

  // inj: beat index during which a start and a write to entry 0 are attempted
  task automatic burst(input logic [2:0] ins, input int sz, input int inj, input bit fin_start);
    exp_ins = ins;
    exp_sz  = 6'(sz);
    for (int k = 0; k < sz; k++) exp_q.push_back(shadow[k]);
    exp_done++;
    start = 1'b1; start_instruction = ins; start_size = 6'(sz);
    cyc();
    start = 1'b0;
    if (sz == 0) begin
      @(negedge clk);
      chk("zero_done", {127'd0, done}, 128'd1);
      chk("zero_busy", {127'd0, busy}, 128'd0);
      chk("zero_size", {122'd0, data_size}, 128'd0);
      chk("zero_instr", {125'd0, instruction}, {125'd0, ins});
    end else begin
      @(negedge clk);
      chk("fetch_busy", {127'd0, busy}, 128'd1);
      chk("fetch_valid", {127'd0, valid_data}, 128'd0);
      for (int k = 0; k < sz; k++) begin
        cyc();
        start = 1'b0; wr_en = 1'b0;
        if (k == inj) begin
          start = 1'b1; start_instruction = ~ins; start_size = 6'd9;
          wr_en = 1'b1; wr_addr = 6'd0;
          wr_data_a = 64'hDEAD_BEEF_DEAD_BEEF; wr_data_b = 64'hDEAD_C0DE_DEAD_C0DE;
        end
        @(negedge clk);
        chk("beat_valid", {127'd0, valid_data}, 128'd1);
        chk("beat_busy", {127'd0, busy}, 128'd1);
      end
      cyc();
      start = 1'b0; wr_en = 1'b0;
      @(negedge clk);
      chk("fin_done", {127'd0, done}, 128'd1);
      chk("fin_busy", {127'd0, busy}, 128'd0);
      chk("fin_valid", {127'd0, valid_data}, 128'd0);
    end
    if (fin_start) begin
      start = 1'b1; start_instruction = 3'd7; start_size = 6'd9;
    end
    cyc();
    start = 1'b0;
    @(negedge clk);
    chk("idle_busy", {127'd0, busy}, 128'd0);
    chk("idle_done", {127'd0, done}, 128'd0);
    chk("hold_instr", {125'd0, instruction}, {125'd0, ins});
    chk("hold_size", {122'd0, data_size}, {122'd0, 6'(sz)});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data_a = '0; wr_data_b = '0;
    start = 1'b0; start_instruction = '0; start_size = '0;
    for (int i = 0; i < 64; i++) shadow[i] = '0;
    #12;
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_done", {127'd0, done}, 128'd0);
    chk("rst_valid", {127'd0, valid_data}, 128'd0);
    chk("rst_vi", {127'd0, valid_instruction}, 128'd0);
    chk("rst_instr", {125'd0, instruction}, 128'd0);
    chk("rst_size", {122'd0, data_size}, 128'd0);
    chk("rst_opab", {mc_data_in_opa, mc_data_in_opb}, 128'd0);
    @(posedge clk); cyc();
    reset = 1'b0;

    // Two-beat burst
    wr(0, 64'h11111111_22222222, 64'h11111111_22222222);
    wr(1, 64'h22222222_11111111, 64'h22222222_11111111);
    burst(3'b000, 2, -1, 1'b0);

    // Fourteen-beat burst in address order
    for (int i = 0; i < 14; i++)
      wr(i, {2{32'(i + 1) * 32'h11111111}}, {32'h66600000 + 32'(i + 1) * 32'h00011111, 32'(i)});
    burst(3'b010, 14, -1, 1'b0);

    // Zero-length burst
    burst(3'b101, 0, -1, 1'b0);

    // Start and write during STREAM are ignored; entry 0 keeps its old value
    burst(3'b001, 6, 2, 1'b0);
    burst(3'b100, 2, -1, 1'b0);

    // Reset during beat 5 of a 14-beat burst
    exp_ins = 3'b011; exp_sz = 6'd14;
    for (int k = 0; k < 14; k++) exp_q.push_back(shadow[k]);
    start = 1'b1; start_instruction = 3'b011; start_size = 6'd14;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 6; k++) cyc();
    #1 reset = 1'b1;
    #1;
    chk("abort_valid", {127'd0, valid_data}, 128'd0);
    chk("abort_vi", {127'd0, valid_instruction}, 128'd0);
    chk("abort_busy", {127'd0, busy}, 128'd0);
    chk("abort_done", {127'd0, done}, 128'd0);
    chk("abort_instr", {125'd0, instruction}, 128'd0);
    chk("abort_size", {122'd0, data_size}, 128'd0);
    chk("abort_opab", {mc_data_in_opa, mc_data_in_opb}, 128'd0);
    chk("abort_beats_seen", 128'(exp_q.size()), 128'd9);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", {127'd0, busy}, 128'd0);
    burst(3'b110, 3, -1, 1'b0);

    // Start in FIN ignored, start in following IDLE accepted
    burst(3'b010, 2, -1, 1'b1);
    burst(3'b101, 3, -1, 1'b0);

    // Maximum-length burst; entry 63 is never streamed
    for (int i = 14; i < 64; i++) wr(i, 64'hA5A5_0000_0000_0000 + 64'(i), 64'h5A5A_0000_0000_0000 + 64'(i));
    burst(3'b111, 63, -1, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_empty", 128'(exp_q.size()), 128'd0);
    chk("done_pending", 128'(exp_done), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
